// File: rtl/f_accum_pkg.sv
// Shared definitions for the float reduction / ordering units.
// Floats are ordered as sign-magnitude words. NaN and Inf are ordered by
// their bit patterns like any other value.
package f_accum_pkg;

  localparam logic [1:0] MODE_MAX    = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_ABSMAX = 2'd2;

  // Strict "a > b" under the sign-magnitude total order for a w-bit word.
  // Any positive value beats any negative value, so +0 beats -0.
  // With equal signs, larger magnitude wins among positives.
  // With equal signs, smaller magnitude wins among negatives.
  function automatic logic sm_gt(input logic [63:0] a,
                                 input logic [63:0] b,
                                 input int unsigned w);
    logic [63:0] sign_bit;
    logic [63:0] mag_mask;
    logic        sa;
    logic        sb;
    logic [63:0] ma;
    logic [63:0] mb;
    logic        res;
    sign_bit = 64'd1 << (w - 1);
    mag_mask = sign_bit - 64'd1;
    sa       = |(a & sign_bit);
    sb       = |(b & sign_bit);
    ma       = a & mag_mask;
    mb       = b & mag_mask;
    if (sa != sb) begin
      res = !sa;
    end else if (!sa) begin
      res = (ma > mb);
    end else begin
      res = (ma < mb);
    end
    return res;
  endfunction

endpackage

// File: rtl/f_sm_compare.sv
// Combinational float comparator.
// gt_o is high when a_i strictly beats b_i under mode_i. Because the test is
// strict, a tie leaves the incumbent in place.
// Mode 3 is reserved and orders like MAX.
module f_sm_compare
  import f_accum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        mode_i,
  output logic              gt_o
);

  // Select the ordering rule for the current mode.
  always_comb begin
    gt_o = 1'b0;
    case (mode_i)
      MODE_MIN:    gt_o = sm_gt(64'(b_i), 64'(a_i), DATA_W);
      MODE_ABSMAX: gt_o = (a_i[DATA_W-2:0] > b_i[DATA_W-2:0]);
      default:     gt_o = sm_gt(64'(a_i), 64'(b_i), DATA_W);
    endcase
  end

endmodule

// File: rtl/f_accum_reduce.sv
// Windowed float reduction unit: MAX / MIN / ABS-MAX of a float stream over
// windows of strideMinusOne+1 elements.
// out1 carries the in-window index of the selected element. outValid flags
// the cycle in which a finished window sits on out0/out1.
module f_accum_reduce
  import f_accum_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STRIDE_W = 16,
  parameter int DELAY_W  = 7,
  parameter int IDX_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                running,
  input  logic [STRIDE_W-1:0] strideMinusOne,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DELAY_W-1:0]  delay0,
  output logic [DATA_W-1:0]   out0,
  output logic [IDX_W-1:0]    out1,
  output logic                outValid
);

  // The delay counter holds both the start delay and the window length.
  localparam int CNT_W = (STRIDE_W > DELAY_W) ? STRIDE_W : DELAY_W;

  logic [CNT_W-1:0]  delay_q, delay_d;
  logic [DATA_W-1:0] stored_q, stored_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [1:0]        mode_q, mode_d;
  logic              primed_q, primed_d;
  logic              valid_q, valid_d;

  logic store;
  logic better;
  logic last;

  assign store = (delay_q == '0);

  // better: the incoming element beats the stored one under the latched mode.
  f_sm_compare #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .a_i    (in0),
    .b_i    (stored_q),
    .mode_i (mode_q),
    .gt_o   (better)
  );

  // The final element of a window is absorbed this cycle. A window of one
  // element is always last. Warm-up elements before the first store are
  // never flagged.
  assign last = running && (primed_q || store) &&
                ((delay_q == CNT_W'(1)) ||
                 (store && (strideMinusOne == '0)));

  // Next state for the counters, the stored value and the flags.
  always_comb begin
    delay_d  = delay_q;
    stored_d = stored_q;
    idx_d    = idx_q;
    count_d  = count_q;
    mode_d   = mode_q;
    primed_d = primed_q;
    valid_d  = last;

    // The delay counter is free-running: it does not depend on running.
    if (run) begin
      delay_d = CNT_W'(delay0);
    end else if (!store) begin
      delay_d = delay_q - CNT_W'(1);
    end else begin
      delay_d = CNT_W'(strideMinusOne);
    end

    if (run) begin
      mode_d = mode;
    end

    if (run) begin
      primed_d = 1'b0;
    end else if (running && store) begin
      primed_d = 1'b1;
    end

    // Element bookkeeping only moves while the accelerator is running.
    if (running) begin
      if (store) begin
        count_d  = IDX_W'(1);
        stored_d = in0;
        idx_d    = '0;
      end else begin
        count_d = count_q + IDX_W'(1);
        if (better) begin
          stored_d = in0;
          idx_d    = count_q;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q  <= '0;
      stored_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      mode_q   <= MODE_MAX;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      delay_q  <= delay_d;
      stored_q <= stored_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  assign out0     = stored_q;
  assign out1     = idx_q;
  assign outValid = valid_q;

endmodule

// File: tb/tb_f_accum_reduce.sv
// Directed bench for f_accum_reduce with hand-computed expected results.
module tb_f_accum_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        running;
  logic [15:0] strideMinusOne;
  logic [1:0]  mode;
  logic [31:0] in0;
  logic [6:0]  delay0;
  logic [31:0] out0;
  logic [15:0] out1;
  logic        outValid;

  int total_cnt  = 0;
  int passed_cnt = 0;

  f_accum_reduce dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .running        (running),
    .strideMinusOne (strideMinusOne),
    .mode           (mode),
    .in0            (in0),
    .delay0         (delay0),
    .out0           (out0),
    .out1           (out1),
    .outValid       (outValid)
  );

  // Clock.
  always #5 clk = ~clk;

  // Advance one clock, then settle just past the edge.
  // Inputs are changed and outputs are checked at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) passed_cnt++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Pulse run with accelerator idle, loading mode, start delay and stride.
  task automatic start(input logic [1:0] m, input logic [6:0] d0, input logic [15:0] s);
    run            = 1'b1;
    running        = 1'b0;
    mode           = m;
    delay0         = d0;
    strideMinusOne = s;
    tick();
    run = 1'b0;
  endtask

  // Present one element with running high for one cycle.
  task automatic feed(input logic [31:0] v);
    running = 1'b1;
    in0     = v;
    tick();
    running = 1'b0;
  endtask

  // Directed stimulus.
  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b0; strideMinusOne = '0;
    mode = 2'd0; in0 = '0; delay0 = '0;
    #12;
    chk("reset_out0", out0, 32'h0);
    chk("reset_out1", 32'(out1), 32'h0);
    chk("reset_valid", 32'(outValid), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // MAX, window 4: 1.0, -2.0, 3.5, 0.5
    start(2'd0, 7'd0, 16'd3);
    feed(32'h3F800000); feed(32'hC0000000); feed(32'h40600000);
    chk("max_valid_early", 32'(outValid), 32'h0);
    feed(32'h3F000000);
    chk("max_valid", 32'(outValid), 32'h1);
    chk("max_out0", out0, 32'h40600000);
    chk("max_out1", 32'(out1), 32'd2);
    tick();
    chk("max_valid_drop", 32'(outValid), 32'h0);

    // MIN, same stream
    start(2'd1, 7'd0, 16'd3);
    feed(32'h3F800000); feed(32'hC0000000); feed(32'h40600000); feed(32'h3F000000);
    chk("min_valid", 32'(outValid), 32'h1);
    chk("min_out0", out0, 32'hC0000000);
    chk("min_out1", 32'(out1), 32'd1);

    // ABSMAX: -4.0, 3.0, -1.0, 2.0
    start(2'd2, 7'd0, 16'd3);
    feed(32'hC0800000); feed(32'h40400000); feed(32'hBF800000); feed(32'h40000000);
    chk("abs_valid", 32'(outValid), 32'h1);
    chk("abs_out0", out0, 32'hC0800000);
    chk("abs_out1", 32'(out1), 32'd0);

    // ABSMAX tie: 2.0, -2.0, 1.0, 1.0 -> first occurrence kept
    start(2'd2, 7'd0, 16'd3);
    feed(32'h40000000); feed(32'hC0000000); feed(32'h3F800000); feed(32'h3F800000);
    chk("tie_out0", out0, 32'h40000000);
    chk("tie_out1", 32'(out1), 32'd0);

    // MAX with -0 then +0, window 2
    start(2'd0, 7'd0, 16'd1);
    feed(32'h80000000); feed(32'h00000000);
    chk("zero_valid", 32'(outValid), 32'h1);
    chk("zero_out0", out0, 32'h00000000);
    chk("zero_out1", 32'(out1), 32'd1);

    // Start delay 2, window 2, six running cycles
    start(2'd0, 7'd2, 16'd1);
    feed(32'h41100000);
    chk("dly_v1", 32'(outValid), 32'h0);
    feed(32'h41000000);
    chk("dly_v2", 32'(outValid), 32'h0);
    feed(32'h3F800000);
    chk("dly_v3", 32'(outValid), 32'h0);
    feed(32'h40000000);
    chk("dly_v4", 32'(outValid), 32'h1);
    chk("dly_w1_out0", out0, 32'h40000000);
    chk("dly_w1_out1", 32'(out1), 32'd1);
    feed(32'h40A00000);
    chk("dly_v5", 32'(outValid), 32'h0);
    chk("dly_restart_out0", out0, 32'h40A00000);
    feed(32'h40400000);
    chk("dly_v6", 32'(outValid), 32'h1);
    chk("dly_w2_out0", out0, 32'h40A00000);
    chk("dly_w2_out1", 32'(out1), 32'd0);

    // Window of one: every element is its own window
    start(2'd0, 7'd0, 16'd0);
    feed(32'h40400000);
    chk("w1_valid_a", 32'(outValid), 32'h1);
    chk("w1_out0_a", out0, 32'h40400000);
    running = 1'b1; in0 = 32'hBF800000; tick();
    chk("w1_valid_b", 32'(outValid), 32'h1);
    chk("w1_out0_b", out0, 32'hBF800000);
    chk("w1_out1_b", 32'(out1), 32'd0);
    running = 1'b0;

    // Mode input changes mid-window: latched MAX still applies
    start(2'd0, 7'd0, 16'd3);
    feed(32'h3F800000);
    mode = 2'd1;
    feed(32'hC0000000); feed(32'h40600000); feed(32'h3F000000);
    chk("modechg_out0", out0, 32'h40600000);
    chk("modechg_out1", 32'(out1), 32'd2);

    // Reserved mode orders like MAX
    start(2'd3, 7'd0, 16'd3);
    feed(32'h3F800000); feed(32'hC0000000); feed(32'h40600000); feed(32'h3F000000);
    chk("rsvd_out0", out0, 32'h40600000);
    chk("rsvd_out1", 32'(out1), 32'd2);

    // Reset mid-window, then a fresh window
    start(2'd0, 7'd0, 16'd3);
    feed(32'h40E00000); feed(32'h40C00000);
    rst = 1'b1;
    #1;
    chk("rst_out0", out0, 32'h0);
    chk("rst_out1", 32'(out1), 32'h0);
    chk("rst_valid", 32'(outValid), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_idle_valid", 32'(outValid), 32'h0);
    start(2'd0, 7'd0, 16'd3);
    feed(32'h3F800000); feed(32'h40000000); feed(32'h3F000000); feed(32'h3E800000);
    chk("post_rst_valid", 32'(outValid), 32'h1);
    chk("post_rst_out0", out0, 32'h40000000);
    chk("post_rst_out1", 32'(out1), 32'd1);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
